drum_memory: RTL and testbench
==============================

DRUM_MEMORY -- requirements
Module: drum_memory

Interface
REQ-001 Parameter ADDR_W, default 11: word address width; the drum holds 2^ADDR_W words.
REQ-002 Parameter WORD_W, default 30: data word width.
REQ-003 Parameter TICK_DIV, default 4, minimum 2: clock cycles per word slot passing under the head.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 resetn  input  1  synchronous, active-low reset.
REQ-006 mem_req_read  input  1  read request, sampled only in IDLE.
REQ-007 mem_req_write  input  1  write request, sampled only in IDLE.
REQ-008 mem_addr  input  ADDR_W  word address, captured with the request.
REQ-009 mem_write_data  input  WORD_W  write data, captured with the request.
REQ-010 mem_read_data  output  WORD_W  registered read data; drives the arithmetic unit's memory-load input.
REQ-011 mem_done  output  1  one-cycle completion pulse; drives do_read_mem for reads.
REQ-012 mem_busy  output  1  high while a request is in progress (SEEK or DONE).
REQ-013 mem_err  output  1  one-cycle pulse when a request is rejected.
REQ-014 drum_pos  output  ADDR_W  current word slot under the head.

Function
REQ-015 Storage: 2^ADDR_W x WORD_W array; resetn does not clear it.
REQ-016 Rotation: tick counter 0..TICK_DIV-1 increments every cycle and wraps to 0.
REQ-017 Rotation: drum_pos increments when tick wraps from TICK_DIV-1 to 0, and wraps from 2^ADDR_W-1 to 0.
REQ-018 Rotation: tick and drum_pos run continuously, independent of request state.
REQ-019 States: IDLE, SEEK, DONE; mem_busy is high in SEEK and DONE.
REQ-020 IDLE: exactly one of read/write high at cycle n -> capture op, addr and data; state is SEEK in cycle n+1.
REQ-021 IDLE: read and write both high -> no capture; mem_err high in cycle n+1; stay IDLE.
REQ-022 SEEK: access cycle m is the first cycle m >= n+1 with drum_pos == captured addr and tick == 0.
REQ-023 SEEK: at end of cycle m, a write updates the array and a read loads mem_read_data; state is DONE in cycle m+1.
REQ-024 SEEK: a request issued while its slot is under the head at tick 0 (cycle n) waits a full rotation.
REQ-025 DONE: mem_done high for exactly one cycle (m+1); state returns to IDLE in cycle m+2.
REQ-026 Requests during SEEK or DONE are ignored and do not raise mem_err; a request may be accepted in cycle m+2.
REQ-027 mem_read_data holds its value until the next read access; writes do not change it.
REQ-028 Latency: between 2 and TICK_DIV*2^ADDR_W+1 cycles from the request cycle to the mem_done cycle.

Reset
REQ-029 resetn low at an edge sets: state IDLE, tick 0, drum_pos 0, mem_read_data 0, mem_done 0, mem_busy 0, mem_err 0.
REQ-030 Reset during SEEK aborts the request with no array write and no mem_done.
REQ-031 Cycle 0 is the first cycle with resetn high; in cycle 0, tick = 0 and drum_pos = 0.

Verification (defaults ADDR_W=11, TICK_DIV=4; cycle 0 per REQ-031)
REQ-032 Write addr 5, data 0x2AAAAAAA, at cycle 0 -> busy cycles 1-21; array write at end of cycle 20; mem_done at cycle 21.
REQ-033 Read addr 5 at cycle 22 -> access at cycle 8212; mem_done at 8213; mem_read_data = 0x2AAAAAAA.
REQ-034 Read addr 0 at cycle 8190 (pos 2047, tick 2) -> access at cycle 8192 after pos wrap; mem_done at 8193.
REQ-035 Read and write both high at cycle 0 -> mem_err at cycle 1; mem_busy stays 0; array unchanged.
REQ-036 Write addr 9 at cycle 0; resetn low at cycle 10 -> all outputs reset; a later read of addr 9 returns the prior contents.
REQ-037 Write accepted at cycle 0; a second request held during cycles 1-21 is ignored; the second request is accepted at cycle 22.

Source files
------------

// File: rtl/drum_memory_if.sv
// Request/response bundle between a drum memory and its client.
interface drum_memory_if #(
  parameter int ADDR_W = 11,
  parameter int WORD_W = 30
);
  logic              mem_req_read;
  logic              mem_req_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_write_data;
  logic [WORD_W-1:0] mem_read_data;
  logic              mem_done;
  logic              mem_busy;
  logic              mem_err;
  logic [ADDR_W-1:0] drum_pos;

  modport master (
    output mem_req_read, mem_req_write, mem_addr, mem_write_data,
    input  mem_read_data, mem_done, mem_busy, mem_err, drum_pos
  );

  modport slave (
    input  mem_req_read, mem_req_write, mem_addr, mem_write_data,
    output mem_read_data, mem_done, mem_busy, mem_err, drum_pos
  );
endinterface

// File: rtl/drum_memory.sv
// Rotating drum store: a request waits until its word slot passes under the
// head at tick 0, then reads or writes that slot.
module drum_memory #(
  parameter int ADDR_W   = 11,
  parameter int WORD_W   = 30,
  parameter int TICK_DIV = 4
) (
  input  logic         clk,
  input  logic         resetn,
  drum_memory_if.slave bus
);
  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEEK = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [TW-1:0]     tick;
  logic [ADDR_W-1:0] pos;
  logic              op_write;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] data_q;
  logic [WORD_W-1:0] rdata;
  logic              err;
  logic [WORD_W-1:0] mem [0:(1<<ADDR_W)-1];

  logic tick_wrap;
  logic hit;

  assign tick_wrap = (tick == TW'(TICK_DIV - 1));
  // Matching in SEEK only means a slot already under the head at request time waits a full turn.
  assign hit       = (state == SEEK) && (pos == addr_q) && (tick == '0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      tick     <= '0;
      pos      <= '0;
      op_write <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      rdata    <= '0;
      err      <= 1'b0;
    end else begin
      tick <= tick_wrap ? '0 : tick + 1'b1;
      if (tick_wrap) pos <= pos + 1'b1;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.mem_req_read && bus.mem_req_write) begin
            err <= 1'b1;
          end else if (bus.mem_req_read || bus.mem_req_write) begin
            op_write <= bus.mem_req_write;
            addr_q   <= bus.mem_addr;
            data_q   <= bus.mem_write_data;
            state    <= SEEK;
          end
        end
        SEEK: begin
          if (hit) begin
            if (!op_write) rdata <= mem[addr_q];
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is never cleared; reset only suppresses a pending write.
  always_ff @(posedge clk) begin
    if (resetn && hit && op_write) mem[addr_q] <= data_q;
  end

  assign bus.mem_read_data = rdata;
  assign bus.mem_done      = (state == DONE);
  assign bus.mem_busy      = (state != IDLE);
  assign bus.mem_err       = err;
  assign bus.drum_pos      = pos;
endmodule

// File: tb/tb_drum_memory.sv
// Directed bench for drum_memory at ADDR_W=11, WORD_W=30, TICK_DIV=4.
module tb_drum_memory;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  drum_memory_if #(.ADDR_W(11), .WORD_W(30)) bus ();

  drum_memory #(.ADDR_W(11), .WORD_W(30), .TICK_DIV(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    bit          rd;
    bit          wr;
    int          addr;
    logic [29:0] wdata;
    int          issue;
    int          done_at;
    logic [29:0] rdata;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    bus.mem_req_read   = 1'b0;
    bus.mem_req_write  = 1'b0;
    bus.mem_addr       = '0;
    bus.mem_write_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    cyc = 0;
    check("rst_pos",   64'(bus.drum_pos), 64'd0);
    check("rst_busy",  64'(bus.mem_busy), 64'd0);
    check("rst_done",  64'(bus.mem_done), 64'd0);
    check("rst_err",   64'(bus.mem_err), 64'd0);
    check("rst_rdata", 64'(bus.mem_read_data), 64'd0);
  endtask

  // Issue one request at cycle `issue`, then follow it to its done pulse.
  task automatic run_req(input string tag, input bit rd, input bit wr, input int addr,
                         input logic [29:0] wdata, input int issue, input int done_at,
                         input logic [29:0] rdata);
    int  done_cyc;
    bit  busy_ok;
    bit  err_seen;
    int  limit;
    while (cyc < issue) step();
    check({tag, "_pos"}, 64'(bus.drum_pos), 64'((issue / 4) % 2048));
    check({tag, "_idle"}, 64'(bus.mem_busy), 64'd0);
    bus.mem_req_read   = rd;
    bus.mem_req_write  = wr;
    bus.mem_addr       = 11'(addr);
    bus.mem_write_data = wdata;
    step();
    idle_inputs();
    done_cyc = -1;
    busy_ok  = 1'b1;
    err_seen = 1'b0;
    limit    = issue + 9000;
    while (done_cyc < 0 && cyc <= limit) begin
      if (!bus.mem_busy) busy_ok = 1'b0;
      if (bus.mem_err) err_seen = 1'b1;
      if (bus.mem_done) done_cyc = cyc;
      else step();
    end
    check({tag, "_done_cycle"}, 64'(done_cyc), 64'(done_at));
    check({tag, "_busy_held"}, 64'(busy_ok), 64'd1);
    check({tag, "_no_err"}, 64'(err_seen), 64'd0);
    check({tag, "_rdata"}, 64'(bus.mem_read_data), 64'(rdata));
    step();
    check({tag, "_done_pulse"}, 64'(bus.mem_done), 64'd0);
    check({tag, "_busy_clear"}, 64'(bus.mem_busy), 64'd0);
  endtask

  initial begin
    int first_done;
    bit err_seen;

    //            rd   wr   addr  wdata          issue done  rdata
    vecs[0] = '{1'b0, 1'b1,    5, 30'h2AAAAAAA,     0,   21, 30'h0};
    vecs[1] = '{1'b1, 1'b0,    5, 30'h0,            0,   21, 30'h2AAAAAAA};
    vecs[2] = '{1'b0, 1'b1,    0, 30'h01234567,     0, 8193, 30'h0};
    vecs[3] = '{1'b1, 1'b0,    0, 30'h0,         8190, 8193, 30'h01234567};
    vecs[4] = '{1'b0, 1'b1, 2047, 30'h3FFFFFFF,     3, 8189, 30'h0};
    vecs[5] = '{1'b1, 1'b0, 2047, 30'h0,            1, 8189, 30'h3FFFFFFF};
    vecs[6] = '{1'b0, 1'b1,    1, 30'h0,            3,    5, 30'h0};
    vecs[7] = '{1'b1, 1'b0,    1, 30'h0,            3,    5, 30'h0};
    vecs[8] = '{1'b0, 1'b1,    9, 30'h00C0FFEE,     0,   37, 30'h0};
    vecs[9] = '{1'b1, 1'b0,    9, 30'h0,           35,   37, 30'h00C0FFEE};

    idle_inputs();
    repeat (2) @(posedge clk);

    for (int i = 0; i < 10; i++) begin
      do_reset();
      run_req($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr,
              vecs[i].wdata, vecs[i].issue, vecs[i].done_at, vecs[i].rdata);
    end

    // Write at cycle 0, read back at cycle 22 -> a full rotation later.
    do_reset();
    run_req("seq_w5", 1'b0, 1'b1, 5, 30'h15555555, 0, 21, 30'h0);
    run_req("seq_r5", 1'b1, 1'b0, 5, 30'h0, 22, 8213, 30'h15555555);

    // Conflicting read+write is rejected and leaves the array alone.
    do_reset();
    bus.mem_req_read   = 1'b1;
    bus.mem_req_write  = 1'b1;
    bus.mem_addr       = 11'd5;
    bus.mem_write_data = 30'h0;
    step();
    idle_inputs();
    check("err_pulse", 64'(bus.mem_err), 64'd1);
    check("err_busy", 64'(bus.mem_busy), 64'd0);
    step();
    check("err_clear", 64'(bus.mem_err), 64'd0);
    check("err_busy2", 64'(bus.mem_busy), 64'd0);
    run_req("err_readback", 1'b1, 1'b0, 5, 30'h0, 2, 21, 30'h15555555);

    // Reset mid-seek aborts the write to addr 9.
    do_reset();
    bus.mem_req_write  = 1'b1;
    bus.mem_addr       = 11'd9;
    bus.mem_write_data = 30'h3EADBEEF;
    step();
    idle_inputs();
    while (cyc < 10) step();
    check("abort_busy_before", 64'(bus.mem_busy), 64'd1);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    cyc = 0;
    check("abort_busy", 64'(bus.mem_busy), 64'd0);
    check("abort_done", 64'(bus.mem_done), 64'd0);
    check("abort_pos", 64'(bus.drum_pos), 64'd0);
    check("abort_rdata", 64'(bus.mem_read_data), 64'd0);
    run_req("abort_readback", 1'b1, 1'b0, 9, 30'h0, 0, 37, 30'h00C0FFEE);

    // A request held through the busy window is ignored, then accepted at cycle 22.
    do_reset();
    bus.mem_req_write  = 1'b1;
    bus.mem_addr       = 11'd5;
    bus.mem_write_data = 30'h15555555;
    step();
    bus.mem_req_write  = 1'b0;
    bus.mem_req_read   = 1'b1;
    bus.mem_addr       = 11'd9;
    bus.mem_write_data = 30'h0;
    first_done = -1;
    err_seen   = 1'b0;
    while (cyc < 22) begin
      if (bus.mem_err) err_seen = 1'b1;
      if (bus.mem_done && first_done < 0) begin
        first_done = cyc;
        check("hold_rdata_after_write", 64'(bus.mem_read_data), 64'd0);
      end
      step();
    end
    check("hold_first_done", 64'(first_done), 64'd21);
    check("hold_no_err", 64'(err_seen), 64'd0);
    check("hold_idle22", 64'(bus.mem_busy), 64'd0);
    step();
    idle_inputs();
    check("hold_accept23", 64'(bus.mem_busy), 64'd1);
    first_done = -1;
    while (first_done < 0 && cyc < 200) begin
      if (bus.mem_done) first_done = cyc;
      else step();
    end
    check("hold_second_done", 64'(first_done), 64'd37);
    check("hold_second_rdata", 64'(bus.mem_read_data), 64'h00C0FFEE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
